// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable divider with a rise-aligned tick. Outputs are registered, and the one-slot config is applied at the HIGH->LOW edge or while disabled.
// Optional macro CLK_DIV_DUTY_EN makes the high-phase length independent of the low phase (cfg_high port).
module clk_div_prog #(
   parameter int WIDTH        = 25,
   parameter int DEFAULT_HALF = 25000000
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] cfg_half,
`ifdef CLK_DIV_DUTY_EN
   input  logic [WIDTH-1:0] cfg_high,
`endif
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             clk_out,
   output logic             tick,
   output logic [WIDTH-1:0] cur_half
);
   typedef enum logic {PH_LOW = 1'b0, PH_HIGH = 1'b1} phase_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_HALF);

   phase_t           phase, phase_nxt;
   logic [WIDTH-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] active_lo, pend_lo;
   logic [WIDTH-1:0] hi_len;
   logic             pend_full;
   logic             tick_q, tick_nxt;
   logic             apply, accept;

`ifdef CLK_DIV_DUTY_EN
   logic [WIDTH-1:0] active_hi, pend_hi;
   assign hi_len = active_hi;
`else
   assign hi_len = active_lo;
`endif

   assign accept = cfg_valid && !pend_full;

   // Next-state: phase sequencing; apply is only ever raised while something is pending
   always_comb begin
      phase_nxt = phase;
      cnt_nxt   = cnt;
      tick_nxt  = 1'b0;
      apply     = 1'b0;
      if (!en) begin
         phase_nxt = PH_LOW;
         cnt_nxt   = '0;
         apply     = pend_full;
      end else if (phase == PH_LOW) begin
         if (cnt == active_lo - ONE) begin
            phase_nxt = PH_HIGH;
            cnt_nxt   = '0;
            tick_nxt  = 1'b1;
         end else begin
            cnt_nxt = cnt + ONE;
         end
      end else begin
         if (cnt == hi_len - ONE) begin
            phase_nxt = PH_LOW;
            cnt_nxt   = '0;
            apply     = pend_full;
         end else begin
            cnt_nxt = cnt + ONE;
         end
      end
   end

   // State register; apply and accept are mutually exclusive through pend_full
   always_ff @(posedge clk_in) begin
      if (rst) begin
         phase     <= PH_LOW;
         cnt       <= '0;
         tick_q    <= 1'b0;
         active_lo <= DEF;
         pend_lo   <= DEF;
         pend_full <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
         active_hi <= DEF;
         pend_hi   <= DEF;
`endif
      end else begin
         phase  <= phase_nxt;
         cnt    <= cnt_nxt;
         tick_q <= tick_nxt;
         if (apply) begin
            active_lo <= pend_lo;
`ifdef CLK_DIV_DUTY_EN
            active_hi <= pend_hi;
`endif
            pend_full <= 1'b0;
         end else if (accept) begin
            pend_lo   <= (cfg_half == '0) ? ONE : cfg_half;
`ifdef CLK_DIV_DUTY_EN
            pend_hi   <= (cfg_high == '0) ? ONE : cfg_high;
`endif
            pend_full <= 1'b1;
         end
      end
   end

   // Outputs are direct register taps: no combinational path from any input
   always_comb begin
      clk_out   = (phase == PH_HIGH);
      tick      = tick_q;
      cfg_ready = !pend_full;
      cur_half  = active_lo;
   end
endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: period-position reference model plus directed scenarios and random traffic.
module tb_clk_div_prog;
   localparam int W   = 8;
   localparam int DEF = 3;

   logic         clk_in = 1'b0;
   logic         rst, en, cfg_valid;
   logic [W-1:0] cfg_half;
`ifdef CLK_DIV_DUTY_EN
   logic [W-1:0] cfg_high;
`endif
   logic         cfg_ready, clk_out, tick;
   logic [W-1:0] cur_half;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference: position within the current period plus phase lengths and a pending slot
   int m_pos, m_lo, m_hi, m_pv, m_plo, m_phi;

   always #5 clk_in = ~clk_in;

   clk_div_prog #(.WIDTH(W), .DEFAULT_HALF(DEF)) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .en       (en),
      .cfg_half (cfg_half),
`ifdef CLK_DIV_DUTY_EN
      .cfg_high (cfg_high),
`endif
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .clk_out  (clk_out),
      .tick     (tick),
      .cur_half (cur_half)
   );

   function automatic int clamp(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic logic [W+2:0] exp_vec();
      return {m_pos >= m_lo, m_pos == m_lo, m_pv == 0, W'(m_lo)};
   endfunction

   function automatic logic [W+2:0] obs_vec();
      return {clk_out, tick, cfg_ready, cur_half};
   endfunction

   // Advance one clock; the model consumes the inputs seen at that edge
   task automatic cycle();
      bit acc;
      @(posedge clk_in);
      if (rst) begin
         m_pos = 0; m_lo = DEF; m_hi = DEF; m_pv = 0;
      end else begin
         acc = cfg_valid && (m_pv == 0);
         if (!en || m_pos == m_lo + m_hi - 1) begin
            m_pos = 0;
            if (m_pv != 0) begin m_lo = m_plo; m_hi = m_phi; m_pv = 0; end
         end else begin
            m_pos++;
         end
         if (acc) begin
            m_plo = clamp(int'(cfg_half));
`ifdef CLK_DIV_DUTY_EN
            m_phi = clamp(int'(cfg_high));
`else
            m_phi = m_plo;
`endif
            m_pv = 1;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
`ifdef CLK_DIV_DUTY_EN
      cfg_high = '0;
`endif
      cycle(); cycle();
      if (obs_vec() !== {1'b0, 1'b0, 1'b1, W'(DEF)}) begin
         errors++; $display("FAIL reset cyc=%0d got=%h want=%h", cyc, obs_vec(), {1'b0, 1'b0, 1'b1, W'(DEF)});
      end
      checks++;
      rst = 1'b0;
   endtask

   task automatic test_default_run();
      int ticks = 0;
      en = 1'b1;
      for (int i = 0; i < 24; i++) begin
         cycle();
         if (tick) ticks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL default_run cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
      end
      if (ticks !== 4) begin
         errors++; $display("FAIL default_ticks got=%0d want=4", ticks);
      end
      checks++;
   endtask

   task automatic test_reconfig();
      bit found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle();
         if (tick) found = 1;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reconfig_wait cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
      end
      if (!found) begin errors++; $display("FAIL reconfig_tick_timeout got=0 want=1"); end
      checks++;
      cycle();
      cfg_valid = 1'b1; cfg_half = W'(5);
      cycle();
      cfg_valid = 1'b0;
      if ({clk_out, cfg_ready} !== 2'b10) begin
         errors++; $display("FAIL reconfig_accept got=%b want=10", {clk_out, cfg_ready});
      end
      checks++;
      for (int i = 0; i < 30; i++) begin
         cycle();
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reconfig_run cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
      end
      if (cur_half !== W'(5)) begin
         errors++; $display("FAIL reconfig_cur_half got=%0d want=5", cur_half);
      end
      checks++;
   endtask

   task automatic test_zero_clamp();
      int ticks = 0;
      cfg_valid = 1'b1; cfg_half = '0;
      cycle();
      cfg_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (i >= 30 && tick) ticks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL zero_clamp cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
      end
      if ({ticks, cur_half} !== {32'd5, W'(1)}) begin
         errors++; $display("FAIL zero_clamp_rate got ticks=%0d half=%0d want ticks=5 half=1", ticks, cur_half);
      end
      checks++;
   endtask

   task automatic test_ignored_offer();
      bit found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (!clk_out) found = 1; else cycle();
      end
      if (!found) begin errors++; $display("FAIL ignored_wait_low got=1 want=0"); end
      checks++;
      cfg_valid = 1'b1; cfg_half = W'(5);
      cycle();
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL ignored_first cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      checks++;
      cfg_half = W'(9);
      cycle();
      cfg_valid = 1'b0;
      for (int i = 0; i < 25; i++) begin
         cycle();
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL ignored_run cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
      end
      if (cur_half !== W'(5)) begin
         errors++; $display("FAIL ignored_cur_half got=%0d want=5", cur_half);
      end
      checks++;
   endtask

   task automatic test_en_drop_rst();
      bit found = 0;
      int n = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle();
         if (tick) found = 1;
      end
      if (!found) begin errors++; $display("FAIL drop_tick_timeout got=0 want=1"); end
      checks++;
      cfg_valid = 1'b1; cfg_half = W'(2);
      cycle();
      cfg_valid = 1'b0;
      en = 1'b0;
      cycle();
      if ({clk_out, tick, cur_half} !== {1'b0, 1'b0, W'(2)}) begin
         errors++; $display("FAIL drop_apply got=%h want=%h", {clk_out, tick, cur_half}, {1'b0, 1'b0, W'(2)});
      end
      checks++;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL drop_idle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
      end
      en = 1'b1;
      cycle();
      rst = 1'b1; cfg_valid = 1'b1; cfg_half = W'(7);
      cycle();
      rst = 1'b0; cfg_valid = 1'b0; en = 1'b0;
      if (obs_vec() !== {1'b0, 1'b0, 1'b1, W'(DEF)}) begin
         errors++; $display("FAIL rst_mid_low got=%h want=%h", obs_vec(), {1'b0, 1'b0, 1'b1, W'(DEF)});
      end
      checks++;
      cycle();
      en = 1'b1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         n++;
         if (tick) found = 1;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reenable cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
      end
      if (n !== DEF) begin
         errors++; $display("FAIL reenable_low_len got=%0d want=%0d", n, DEF);
      end
      checks++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 199) == 0);
         en        = ($urandom_range(0, 9) != 0);
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_half  = W'($urandom_range(0, 6));
`ifdef CLK_DIV_DUTY_EN
         cfg_high  = W'($urandom_range(0, 6));
`endif
         cycle();
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
      end
      rst = 1'b0; cfg_valid = 1'b0;
   endtask

`ifdef CLK_DIV_DUTY_EN
   task automatic test_duty();
      rst = 1'b1; en = 1'b0;
      cycle();
      rst = 1'b0;
      cfg_valid = 1'b1; cfg_half = W'(2); cfg_high = W'(1);
      cycle();
      cfg_valid = 1'b0;
      cycle();
      en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (obs_vec() !== exp_vec() || tick !== clk_out) begin
            errors++; $display("FAIL duty cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         checks++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_default_run();
      test_reconfig();
      test_zero_clamp();
      test_ignored_offer();
      test_en_drop_rst();
      test_random();
`ifdef CLK_DIV_DUTY_EN
      test_duty();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable clock divider and tick generator. It is the parametrised successor to the fixed 1 Hz divider. It derives a square wave `clk_out` and a one-cycle `tick` strobe from `clk_in`. The half-period is loaded at run time through a valid/ready port and takes effect only at a period boundary, so the output never glitches. It sits between the board oscillator and any slow-rate logic (display scan, debounce, blink), and also serves as a clock-enable source.

## Interface
- `WIDTH`, 25: counter and config width; must hold `DEFAULT_HALF`.
- `DEFAULT_HALF`, 25000000: active half-period after reset, in `clk_in` cycles (1 Hz from 50 MHz).

Ports:
- `clk_in`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  run enable.
- `cfg_half`  in  WIDTH  requested half-period (low phase when `CLK_DIV_DUTY_EN` is defined).
- `cfg_high`  in  WIDTH  requested high-phase length; port exists only with `CLK_DIV_DUTY_EN`.
- `cfg_valid`  in  1  config offer.
- `cfg_ready`  out  1  config slot free.
- `clk_out`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle strobe, high in the first cycle of each high phase.
- `cur_half`  out  WIDTH  half-period currently in force.

## Operation
- Registers:
  - `cnt` (WIDTH bits)
  - `active_lo` and `active_hi`
  - `pend_lo` and `pend_hi`
  - `pend_full`
  - `clk_out`, `tick`
- Config capture: when `cfg_valid && cfg_ready`, latch the value(s) into pend and set `pend_full`.
  - `cfg_ready = !pend_full`.
  - An offer made while `pend_full` is set is ignored, not queued.
- Zero clamp: a captured value of 0 is stored as 1.
- Phases, with `en` = 1:
  - LOW: `clk_out` = 0 for exactly `active_lo` cycles, then go to HIGH.
  - HIGH: `clk_out` = 1 for exactly `active_hi` cycles, then go to LOW.
  - `cnt` counts cycles within a phase; it clears on every phase change.
- Without the macro, `active_hi` always equals `active_lo`.
- Config apply point: the cycle in which HIGH ends (`clk_out` 1→0).
  - pend is copied into active and `pend_full` clears.
  - The new lengths govern the LOW phase that starts that cycle.
  - The in-progress HIGH phase always completes at its old length.
- `en` = 0:
  - Next cycle: `cnt` = 0, `clk_out` = 0, `tick` = 0.
  - A pending config is applied in that cycle.
  - Held idle until `en` returns.
- Re-enable: the first cycle `en` is sampled high begins a full-length LOW phase.
- Reset (any time, including mid-phase or with a config pending):
  - `cnt` = 0, `clk_out` = 0, `tick` = 0.
  - `active_lo` = `active_hi` = `DEFAULT_HALF`.
  - `pend_full` = 0, so `cfg_ready` = 1.
  - `rst` has priority over `en` and `cfg_valid`.
- `cur_half` = `active_lo`.

## Timing
- `clk_out` level changes are registered, with no combinational path from any input.
- Period = `active_lo` + `active_hi` cycles.
- `tick` is high in exactly the same cycle that `clk_out` first reads 1; it is low otherwise.
  - With `active_hi` = 1, `tick` and `clk_out` are identical.
- Config latency:
  - The accept cycle sets `pend_full`.
  - The earliest effect is at the next HIGH→LOW transition, or one cycle later if `en` = 0.
  - `cfg_ready` reasserts the cycle after apply.
- Simultaneous accept and apply in one cycle cannot occur, because `cfg_ready` is low whenever something is pending.
- Counter compare is `cnt == active_x - 1`, so no overflow occurs for any in-range value.

## Configuration
- Macro `CLK_DIV_DUTY_EN`.
- Defined:
  - The `cfg_high` port exists.
  - The low and high phase lengths are independent, giving arbitrary duty cycle.
  - `cfg_high` is captured and clamped with `cfg_half`.
- Undefined:
  - No `cfg_high` port.
  - Both phases use `cfg_half`, giving 50% duty.
  - The `pend_hi` and `active_hi` registers are omitted.

## Test plan
- Reset then `en` = 1, `DEFAULT_HALF` overridden to 3:
  - `clk_out` runs 3 low, 3 high, repeating.
  - `tick` pulses every 6 cycles, aligned to each rise.
  - `cur_half` = 3.
- Running with half 3, `cfg_half` = 5 accepted in the 2nd cycle of a HIGH phase:
  - That HIGH phase lasts 3 cycles; then 5 low, 5 high.
  - `cfg_ready` is low from the accept until the cycle after the 1→0 transition.
- `cfg_half` = 0 accepted:
  - Stored as 1; `clk_out` toggles every cycle.
  - `tick` is high every other cycle; `cur_half` = 1.
- Second `cfg_valid` (value 9) while a pending 5 is held:
  - 9 is ignored; 5 is applied; `cfg_ready` stays low throughout.
- `en` dropped mid-HIGH, then `rst` pulsed mid-LOW:
  - After the `en` drop, `clk_out` = 0 the next cycle and the pending config is applied.
  - After `rst`, all outputs are reset and `cur_half` = `DEFAULT_HALF`.
  - Re-enabling gives a full low phase.
- With `CLK_DIV_DUTY_EN`, `cfg_half` = 2, `cfg_high` = 1:
  - Period 3, `clk_out` pattern 0,0,1.
  - `tick` equals `clk_out`.
